// File: rtl/riscv_mc_top.sv
// rtl/riscv_mc_top.sv - multicycle RV32I-subset CPU with unified memory and external loader port
module riscv_mc_top #(
    parameter int          MEM_WORDS = 128,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IR_SW,
    input  logic        IED,
    input  logic        IEA,
    input  logic        XWE,
    input  logic        XED,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
    logic [31:0]   a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [AW-1:0] ext_addr_q, ext_addr_d;
    logic [31:0]   mem_q [MEM_WORDS];
    logic [31:0]   rf_q [32];

    logic          mem_we, rf_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata, rf_wdata;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, rs1_val, rs2_val, alu_r;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_jal;
    logic        cpu_mem_sel;
    logic [AW-1:0] cpu_idx;
    logic [31:0] cpu_rdata;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Any encoding not matched here decodes as a NOP.
    assign is_r    = (opcode == 7'b0110011) &&
                     (((funct7 == 7'b0000000) &&
                       ((funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                        (funct3 == 3'b100) || (funct3 == 3'b010))) ||
                      ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign is_jal  = (opcode == 7'b1101111);

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    always_comb begin
        alu_r = 32'd0;
        case (funct3)
            3'b000:  alu_r = funct7[5] ? (a_q - b_q) : (a_q + b_q);
            3'b111:  alu_r = a_q & b_q;
            3'b110:  alu_r = a_q | b_q;
            3'b100:  alu_r = a_q ^ b_q;
            3'b010:  alu_r = {31'd0, $signed(a_q) < $signed(b_q)};
            default: alu_r = 32'd0;
        endcase
    end

    assign cpu_mem_sel = (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign cpu_idx     = cpu_mem_sel ? alu_out_q[AW+1:2] : pc_q[AW+1:2];
    assign cpu_rdata   = mem_q[cpu_idx];
    assign ReadData    = IR_SW ? mem_q[ext_addr_q] : cpu_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!IR_SW) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    if (is_lw || is_sw)  state_d = S_MEMADR;
                    else if (is_r)       state_d = S_EXECR;
                    else if (is_addi)    state_d = S_EXECI;
                    else if (is_beq)     state_d = S_BEQ;
                    else if (is_jal)     state_d = S_JAL;
                    else                 state_d = S_FETCH;
                end
                S_MEMADR:   state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_d = S_MEMWB;
                S_MEMWB:    state_d = S_FETCH;
                S_MEMWRITE: state_d = S_FETCH;
                S_EXECR:    state_d = S_ALUWB;
                S_EXECI:    state_d = S_ALUWB;
                S_ALUWB:    state_d = S_FETCH;
                S_JAL:      state_d = S_ALUWB;
                S_BEQ:      state_d = S_FETCH;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_d       = pc_q;
        old_pc_d   = old_pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        mdr_d      = mdr_q;
        ext_addr_d = ext_addr_q;
        mem_we     = 1'b0;
        mem_widx   = ext_addr_q;
        mem_wdata  = WriteData;
        rf_we      = 1'b0;
        rf_wdata   = alu_out_q;
        if (IR_SW) begin
            if (XED && IEA) ext_addr_d = WriteData[AW+1:2];
            mem_we = IED && XWE && MemWrite;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_d     = cpu_rdata;
                    pc_d     = pc_q + 32'd4;
                    old_pc_d = pc_q;
                end
                S_DECODE: begin
                    a_d       = rs1_val;
                    b_d       = rs2_val;
                    alu_out_d = old_pc_q + (is_jal ? imm_j : imm_b);
                end
                S_MEMADR:  alu_out_d = a_q + (is_sw ? imm_s : imm_i);
                S_MEMREAD: mdr_d = cpu_rdata;
                S_MEMWB: begin
                    rf_we    = (rd != 5'd0) && !reset;
                    rf_wdata = mdr_q;
                end
                // Reset in this cycle aborts the store.
                S_MEMWRITE: begin
                    mem_we    = !reset;
                    mem_widx  = alu_out_q[AW+1:2];
                    mem_wdata = b_q;
                end
                S_EXECR: alu_out_d = alu_r;
                S_EXECI: alu_out_d = a_q + imm_i;
                S_ALUWB: rf_we = (rd != 5'd0) && !reset;
                S_JAL: begin
                    pc_d      = alu_out_q;
                    alu_out_d = old_pc_q + 32'd4;
                end
                S_BEQ: if (a_q == b_q) pc_d = alu_out_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            old_pc_q   <= RESET_PC;
            ir_q       <= 32'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            alu_out_q  <= 32'd0;
            mdr_q      <= 32'd0;
            ext_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            old_pc_q   <= old_pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            alu_out_q  <= alu_out_d;
            mdr_q      <= mdr_d;
            ext_addr_q <= ext_addr_d;
        end
    end

    // Memory and register file are never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= mem_wdata;
        if (rf_we)  rf_q[rd] <= rf_wdata;
    end
endmodule

// File: tb/tb_riscv_mc_top.sv
// tb/tb_riscv_mc_top.sv - self-checking bench for riscv_mc_top
module tb_riscv_mc_top;
    logic        clk;
    logic        reset, IR_SW, IED, IEA, XWE, XED, MemWrite;
    logic [31:0] WriteData, ReadData;

    riscv_mc_top #(.MEM_WORDS(128), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .IR_SW(IR_SW), .IED(IED), .IEA(IEA),
        .XWE(XWE), .XED(XED), .MemWrite(MemWrite),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int OP_WR = 0, OP_RD = 1, OP_NOWR = 2, OP_SAME = 3, OP_RST = 4, OP_CUR = 5;
    localparam logic [31:0] SPIN_PC = 32'd328;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vecs [19];
    logic [31:0] prog [21];
    logic [31:0] m_mem [128];
    logic [31:0] m_rf [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IED = 0; IEA = 0; XWE = 0; XED = 0; MemWrite = 0;
    endtask

    task automatic ld_addr(input logic [31:0] a);
        IR_SW = 1; XED = 1; IEA = 1; WriteData = a;
        tick(1);
        idle();
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
        ld_addr(a);
        IED = 1; XWE = 1; MemWrite = 1; WriteData = d;
        tick(1);
        idle();
    endtask

    task automatic ld_read(input logic [31:0] a, output logic [31:0] d);
        ld_addr(a);
        d = ReadData;
    endtask

    task automatic start_run();
        reset = 1; IR_SW = 1;
        tick(1);
        IR_SW = 0;
        tick(1);
        reset = 0;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] r2);
        return {imm[11:5], r2, 5'd0, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [4:0]  rd, r1, r2;
        logic [11:0] imm;
        logic [31:0] w;
        rd  = 5'($urandom_range(0, 31));
        r1  = 5'($urandom_range(0, 31));
        r2  = 5'($urandom_range(0, 31));
        imm = 12'(32'h160 + 4 * $urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                case ($urandom_range(0, 5))
                    0:       w = enc_r(7'h00, r2, r1, 3'b000, rd);
                    1:       w = enc_r(7'h20, r2, r1, 3'b000, rd);
                    2:       w = enc_r(7'h00, r2, r1, 3'b111, rd);
                    3:       w = enc_r(7'h00, r2, r1, 3'b110, rd);
                    4:       w = enc_r(7'h00, r2, r1, 3'b100, rd);
                    default: w = enc_r(7'h00, r2, r1, 3'b010, rd);
                endcase
            end
            4: w = enc_i(12'($urandom_range(0, 4095)), r1, 3'b000, rd, 7'h13);
            5: w = enc_i(imm, 5'd0, 3'b010, rd, 7'h03);
            6: w = enc_sw(imm, r2);
            7: w = {7'd0, ($urandom_range(0, 1) != 0) ? r1 : r2, r1, 3'b000, 4'b0100, 1'b0, 7'h63};
            8: w = {1'b0, 10'd4, 1'b0, 8'd0, rd, 7'h6f};
            default: begin
                w = $urandom();
                w[6:0] = 7'h7f;
            end
        endcase
        return w;
    endfunction

    // Instruction-level reference: executes the program word by word from the ISA rules.
    task automatic model_run(output int cyc);
        logic [31:0] pc, ir, a, b, res, nxt, addr;
        logic        wr;
        pc = 0; cyc = 0;
        for (int s = 0; s < 500 && pc != SPIN_PC; s++) begin
            ir  = m_mem[pc[8:2]];
            a   = m_rf[ir[19:15]];
            b   = m_rf[ir[24:20]];
            nxt = pc + 4; wr = 0; res = 0;
            case (ir[6:0])
                7'h33: begin
                    wr = 1; cyc += 4;
                    case ({ir[31:25], ir[14:12]})
                        10'b0000000_000: res = a + b;
                        10'b0100000_000: res = a - b;
                        10'b0000000_111: res = a & b;
                        10'b0000000_110: res = a | b;
                        10'b0000000_100: res = a ^ b;
                        10'b0000000_010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: begin wr = 0; cyc -= 2; end
                    endcase
                end
                7'h13: if (ir[14:12] == 3'b000) begin
                    wr = 1; cyc += 4;
                    res = a + {{20{ir[31]}}, ir[31:20]};
                end else cyc += 2;
                7'h03: if (ir[14:12] == 3'b010) begin
                    wr = 1; cyc += 5;
                    addr = a + {{20{ir[31]}}, ir[31:20]};
                    res = m_mem[addr[8:2]];
                end else cyc += 2;
                7'h23: if (ir[14:12] == 3'b010) begin
                    cyc += 4;
                    addr = a + {{20{ir[31]}}, ir[31:25], ir[11:7]};
                    m_mem[addr[8:2]] = b;
                end else cyc += 2;
                7'h63: if (ir[14:12] == 3'b000) begin
                    cyc += 3;
                    if (a == b) nxt = pc + {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                end else cyc += 2;
                7'h6f: begin
                    cyc += 4; wr = 1; res = pc + 4;
                    nxt = pc + {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                end
                default: cyc += 2;
            endcase
            if (wr && ir[11:7] != 5'd0) m_rf[ir[11:7]] = res;
            pc = nxt;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          cyc;

        vecs[0]  = '{OP_WR,   32'h10,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{OP_RD,   32'h10,  32'h0,        32'hDEADBEEF};
        vecs[2]  = '{OP_WR,   32'h14,  32'h12345678, 32'h0};
        vecs[3]  = '{OP_RD,   32'h14,  32'h0,        32'h12345678};
        vecs[4]  = '{OP_NOWR, 32'h10,  32'hFFFFFFFF, 32'h0};
        vecs[5]  = '{OP_RD,   32'h10,  32'h0,        32'hDEADBEEF};
        vecs[6]  = '{OP_SAME, 32'h14,  32'h20,       32'h0};
        vecs[7]  = '{OP_RD,   32'h14,  32'h0,        32'h20};
        vecs[8]  = '{OP_WR,   32'h20,  32'hCAFEF00D, 32'h0};
        vecs[9]  = '{OP_CUR,  32'h0,   32'h0,        32'hCAFEF00D};
        vecs[10] = '{OP_WR,   32'h00,  32'h0BADC0DE, 32'h0};
        vecs[11] = '{OP_WR,   32'h1FC, 32'h5A5A5A5A, 32'h0};
        vecs[12] = '{OP_RST,  32'h0,   32'h0,        32'h0};
        vecs[13] = '{OP_CUR,  32'h0,   32'h0,        32'h0BADC0DE};
        vecs[14] = '{OP_RD,   32'h10,  32'h0,        32'hDEADBEEF};
        vecs[15] = '{OP_RD,   32'h213, 32'h0,        32'hDEADBEEF};
        vecs[16] = '{OP_RD,   32'h1FC, 32'h0,        32'h5A5A5A5A};
        vecs[17] = '{OP_RD,   32'h20,  32'h0,        32'hCAFEF00D};
        vecs[18] = '{OP_RD,   32'h14,  32'h0,        32'h20};

        prog = '{32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
                 32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463, 32'h00000293,
                 32'h0023A233, 32'h005203B3, 32'h402383B3, 32'h0471AA23, 32'h06002103,
                 32'h005104B3, 32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
                 32'h00210063};

        reset = 1; IR_SW = 1; WriteData = 0;
        idle();
        tick(2);
        reset = 0;

        for (int i = 0; i < 19; i++) begin
            case (vecs[i].op)
                OP_WR: ld_write(vecs[i].addr, vecs[i].data);
                OP_RD: begin
                    ld_read(vecs[i].addr, d);
                    check($sformatf("loader_vec%0d", i), d, vecs[i].exp);
                end
                OP_NOWR: begin
                    ld_addr(vecs[i].addr);
                    IED = 1; XWE = 1; MemWrite = 0; WriteData = vecs[i].data;
                    tick(1);
                    idle();
                end
                OP_SAME: begin
                    ld_addr(vecs[i].addr);
                    XED = 1; IEA = 1; IED = 1; XWE = 1; MemWrite = 1; WriteData = vecs[i].data;
                    tick(1);
                    idle();
                end
                OP_RST: begin
                    IR_SW = 1; reset = 1;
                    tick(1);
                    reset = 0;
                end
                default: check($sformatf("loader_vec%0d_cur", i), ReadData, vecs[i].exp);
            endcase
        end

        // Fixed program: final store lands on exactly the 71st run edge.
        for (int i = 0; i < 21; i++) ld_write(32'(4 * i), prog[i]);
        ld_write(32'h60, 32'h0);
        ld_write(32'h64, 32'h0);
        start_run();
        check("run_readdata_fetch0", ReadData, prog[0]);
        tick(70);
        IR_SW = 1;
        ld_read(32'h64, d); check("prog_no_store_at_70", d, 32'h0);
        ld_read(32'h60, d); check("prog_mem60", d, 32'd7);
        IR_SW = 0;
        tick(1);
        ld_read(32'h64, d); check("prog_mem64_at_71", d, 32'd25);
        IR_SW = 0;
        tick(20);
        ld_read(32'h64, d); check("prog_mem64_spin", d, 32'd25);
        ld_read(32'h60, d); check("prog_mem60_spin", d, 32'd7);

        // Reset on the store cycle must suppress the write.
        ld_write(32'h64, 32'h0);
        start_run();
        tick(70);
        reset = 1;
        tick(1);
        IR_SW = 1;
        tick(1);
        reset = 0;
        ld_read(32'h64, d); check("reset_aborts_sw", d, 32'h0);

        // Halt mid-run with external strobes active while running.
        ld_write(32'h64, 32'h0);
        start_run();
        XED = 1; IEA = 1; IED = 1; XWE = 1; MemWrite = 1; WriteData = 32'h64;
        tick(30);
        idle();
        IR_SW = 1;
        tick(20);
        IR_SW = 0;
        tick(40);
        IR_SW = 1;
        ld_read(32'h64, d); check("halt_freezes", d, 32'h0);
        IR_SW = 0;
        tick(1);
        ld_read(32'h64, d); check("halt_resume_result", d, 32'd25);
        ld_read(32'h60, d); check("halt_resume_mem60", d, 32'd7);

        // Randomized programs: init regs, random body, dump regs to 0x180.., spin.
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 128; w++) m_mem[w] = 32'h0;
            for (int w = 0; w < 32; w++) m_rf[w] = 32'h0;
            for (int w = 0; w < 31; w++)
                m_mem[w] = enc_i(12'($urandom_range(0, 4095)), 5'd0, 3'b000, 5'(w + 1), 7'h13);
            for (int w = 31; w < 51; w++) m_mem[w] = rnd_instr();
            for (int w = 0; w < 31; w++) m_mem[51 + w] = enc_sw(12'(32'h180 + 4 * w), 5'(w + 1));
            m_mem[82] = 32'h00000063;
            for (int w = 88; w < 96; w++) m_mem[w] = $urandom();
            for (int w = 0; w < 83; w++) ld_write(32'(4 * w), m_mem[w]);
            for (int w = 88; w < 128; w++) ld_write(32'(4 * w), m_mem[w]);
            model_run(cyc);
            start_run();
            tick(cyc + 60);
            IR_SW = 1;
            for (int w = 88; w < 128; w++) begin
                ld_read(32'(4 * w), d);
                check($sformatf("rand%0d_word%0d", r, w), d, m_mem[w]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
